data_memory_unit: RTL and testbench
===================================

Name: data_memory_unit

Overview:
Parametrised successor to the CPU's single-cycle word-only data memory. Supports byte, halfword and word loads and stores, with sign or zero extension and little-endian lane merging. Adds a valid/ready request handshake, a configurable read/write latency and detection of misaligned or out-of-range accesses. Sits between the CPU's ALU address path and the register-write mux; the CPU stalls while req_ready is low.

Parameters:
DEPTH, 32, number of 32-bit words in the array (power of 2, 4..1024)
LATENCY, 1, wait cycles between accept and response (0..7)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept; transfer occurs when req_valid && req_ready
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_error  out  1  qualified by resp_valid; access rejected
initial_values  in  32 x DEPTH  array contents loaded during reset
memory_check  out  32 x DEPTH  live array contents, for debug and bench use

Behaviour:
- Reset (reset_n low at posedge clk): mem[i] <= initial_values[i]; state = IDLE; wait counter = 0; resp_valid = 0; resp_rdata = 0; resp_error = 0. req_ready = 0 while reset_n is low.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready = 1. On transfer, capture write, size, unsigned, addr and wdata. Go to WAIT with counter = LATENCY-1, or go directly to RESP if LATENCY = 0.
  - WAIT: req_ready = 0. Decrement the counter; go to RESP on the edge where the counter is 0.
  - RESP: req_ready = 0; resp_valid = 1 for exactly one cycle. Next state is IDLE.
- Response timing: resp_valid is asserted LATENCY+1 cycles after the accept edge. Back-to-back throughput is one access per LATENCY+2 cycles.
- Commit point: both store commit and load array sampling happen on the edge entering RESP. A load issued after a store always sees the stored data.
- Error conditions (resp_error = 1):
  - size 11;
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] != 0;
  - word index addr[31:2] >= DEPTH.
  On error: no array write, resp_rdata = 0.
- Byte lanes, little-endian, lane = addr[1:0]:
  - Byte store replaces bits [8*lane+7 : 8*lane] only.
  - Halfword store replaces bits [15:0] or [31:16] only.
  - Loads extract the same lane and extend to 32 bits per req_unsigned. req_unsigned is ignored for word loads.
- Store responses: resp_rdata = 0, resp_error per the checks above.
- Reset mid-operation: the pending access is aborted. No write is committed unless RESP was already entered. No resp_valid is produced.
- req_valid asserted while req_ready = 0 is ignored; the requester must hold the request.
- Outputs resp_valid, resp_rdata and resp_error are registered.

Optional Feature:
DMEM_ERR_COUNT_EN
- Defined:
  - Adds output err_count, 16 bits.
  - Increments on every RESP cycle with resp_error = 1 and saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset with initial_values[3] = 32'hDEADBEEF; load word addr 0x0C, LATENCY = 1 -> resp_valid 2 cycles after accept, resp_rdata = 32'hDEADBEEF, resp_error = 0.
- Store byte 8'hA5 to addr 0x0D over 32'hDEADBEEF -> memory_check[3] = 32'hDEADA5EF. Signed byte load 0x0D -> 32'hFFFFFFA5; unsigned -> 32'h000000A5.
- Halfword store 16'h8001 to 0x12, then signed halfword load 0x12 -> 32'hFFFF8001. Bits [15:0] of word 4 are unchanged.
- Word load 0x02, halfword load 0x03, size 11, and word load 0x80 with DEPTH = 32 -> resp_error = 1 and resp_rdata = 0 in each case. Word store to 0x80 -> no memory_check change.
- Back-to-back requests with req_valid held high, LATENCY = 0 and LATENCY = 3 -> accepts spaced exactly 2 and 5 cycles apart. req_ready is low in WAIT and RESP.
- Store accepted, reset_n driven low during WAIT -> no resp_valid, array equals initial_values. With DMEM_ERR_COUNT_EN defined: 3 errored accesses -> err_count = 3, and reset clears it to 0.

Source files
------------

// File: rtl/data_memory_unit.sv
// Byte/halfword/word data memory with valid/ready request handshake, configurable latency and access checking.
// Optional: define DMEM_ERR_COUNT_EN to add the saturating 16-bit err_count output.
module data_memory_unit #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [1:0]             req_size,
  input  logic                   req_unsigned,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_wdata,
  output logic                   resp_valid,
  output logic [31:0]            resp_rdata,
  output logic                   resp_error,
  input  logic [DEPTH-1:0][31:0] initial_values,
  output logic [DEPTH-1:0][31:0] memory_check
`ifdef DMEM_ERR_COUNT_EN
  ,
  output logic [15:0]            err_count
`endif
);

  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = 3;
  localparam int unsigned CNT_INIT = (LATENCY == 0) ? 0 : LATENCY - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_t                  state, next_state;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic                    capture, commit;
  req_t                    req_live, req_q, req_cur;
  logic [DEPTH-1:0][31:0]  mem;
  logic [IDX_W-1:0]        idx;
  logic                    acc_err;
  logic [31:0]             word, wr_word, ld_data;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [31:0]             rd_q;
  logic                    err_q;

  assign req_ready    = reset_n && (state == IDLE);
  assign memory_check = mem;

  // State and wait counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_d;
    end
  end

  // Next state, capture and commit strobes
  always_comb begin
    next_state = state;
    cnt_d      = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          if (LATENCY == 0) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            cnt_d      = CNT_W'(CNT_INIT);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) next_state = RESP;
        else           cnt_d = cnt - CNT_W'(1);
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    commit = (state != RESP) && (next_state == RESP);
  end

  // With zero latency the commit edge is also the accept edge, so use the live request in IDLE
  always_comb begin
    req_live = '{write: req_write, size: req_size, uns: req_unsigned,
                 addr: req_addr, wdata: req_wdata};
    req_cur  = (state == IDLE) ? req_live : req_q;
  end

  // Access checks, little-endian lane merge and load extension
  always_comb begin
    idx     = req_cur.addr[IDX_W+1:2];
    acc_err = (req_cur.size == 2'b11)
            || ((req_cur.size == 2'b01) && req_cur.addr[0])
            || ((req_cur.size == 2'b10) && (req_cur.addr[1:0] != 2'b00))
            || (req_cur.addr[31:IDX_W+2] != '0);
    word    = mem[idx];
    wr_word = word;
    case (req_cur.size)
      2'b00:   wr_word[{req_cur.addr[1:0], 3'b000} +: 8]  = req_cur.wdata[7:0];
      2'b01:   wr_word[{req_cur.addr[1], 4'b0000} +: 16] = req_cur.wdata[15:0];
      default: wr_word = req_cur.wdata;
    endcase
    ld_byte = word[{req_cur.addr[1:0], 3'b000} +: 8];
    ld_half = word[{req_cur.addr[1], 4'b0000} +: 16];
    case (req_cur.size)
      2'b00:   ld_data = req_cur.uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = req_cur.uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = word;
    endcase
  end

  // Array, captured request and response registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem        <= initial_values;
      req_q      <= '0;
      rd_q       <= '0;
      err_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      if (capture) req_q <= req_live;
      if (commit) begin
        err_q <= acc_err;
        rd_q  <= (acc_err || req_cur.write) ? 32'd0 : ld_data;
        if (req_cur.write && !acc_err) mem[idx] <= wr_word;
      end
      resp_valid <= (state == RESP);
      resp_error <= (state == RESP) && err_q;
      resp_rdata <= (state == RESP) ? rd_q : 32'd0;
    end
  end

`ifdef DMEM_ERR_COUNT_EN
  // Saturating count of rejected accesses
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if ((state == RESP) && err_q && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_memory_unit.sv
// Randomized scoreboard bench for data_memory_unit against an arithmetic reference model.
module tb_data_memory_unit;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LAT   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset_n;
  logic                   req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]             req_size;
  logic [31:0]            req_addr, req_wdata;
  logic                   resp_valid, resp_error;
  logic [31:0]            resp_rdata;
  logic [DEPTH-1:0][31:0] init_vals, mem_chk, mem_chk0, mem_chk3;

  logic                   tp_valid;
  logic                   rdy0, rv0, er0, rdy3, rv3, er3;
  logic [31:0]            rd0, rd3;
`ifdef DMEM_ERR_COUNT_EN
  logic [15:0]            err_count, err_count0, err_count3;
`endif

  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .initial_values(init_vals), .memory_check(mem_chk)
`ifdef DMEM_ERR_COUNT_EN
    , .err_count(err_count)
`endif
  );

  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(0)) u_l0 (
    .clk(clk), .reset_n(reset_n), .req_valid(tp_valid), .req_ready(rdy0),
    .req_write(1'b0), .req_size(2'b10), .req_unsigned(1'b0),
    .req_addr(32'h0000_000C), .req_wdata(32'd0), .resp_valid(rv0),
    .resp_rdata(rd0), .resp_error(er0),
    .initial_values(init_vals), .memory_check(mem_chk0)
`ifdef DMEM_ERR_COUNT_EN
    , .err_count(err_count0)
`endif
  );

  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .req_valid(tp_valid), .req_ready(rdy3),
    .req_write(1'b0), .req_size(2'b10), .req_unsigned(1'b0),
    .req_addr(32'h0000_000C), .req_wdata(32'd0), .resp_valid(rv3),
    .resp_rdata(rd3), .resp_error(er3),
    .initial_values(init_vals), .memory_check(mem_chk3)
`ifdef DMEM_ERR_COUNT_EN
    , .err_count(err_count3)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference model: whole-array image plus expected responses
  logic [DEPTH-1:0][31:0] model;
  typedef struct {
    logic [31:0]            rdata;
    logic                   err;
    int                     due;
    logic [DEPTH-1:0][31:0] snap;
  } exp_t;
  exp_t sbq[$];

  function automatic void model_access(input logic w, input logic [1:0] sz, input logic u,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic er);
    int unsigned nbytes, sh, wi;
    logic [31:0] mask, v;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    sh     = 8 * (a % 4);
    wi     = a / 4;
    er     = (sz == 2'd3) || ((a % nbytes) != 0) || (wi >= DEPTH);
    rd     = 32'd0;
    if (!er) begin
      mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      if (w) begin
        model[wi] = (model[wi] & ~(mask << sh)) | ((wd & mask) << sh);
      end else begin
        v = (model[wi] >> sh) & mask;
        if (!u && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
        rd = v;
      end
    end
  endfunction

  // Issue one request at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int   guard;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    model_access(w, sz, u, a, wd, e.rdata, e.err);
    e.due  = cyc + 1 + int'(LAT) + 1;
    e.snap = model;
    sbq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (sbq.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 32'(sbq.size()), 32'd0);
  endtask

  task automatic count_bad(output int bad);
    bad = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mem_chk[i] !== init_vals[i]) bad++;
  endtask

  // Entered at a negedge: hold reset two edges, check reset state, release
  task automatic do_reset();
    int bad;
    reset_n = 1'b0; req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    count_bad(bad);
    check("reset_mem_words_differing", 32'(bad), 32'd0);
    sbq.delete();
    model   = init_vals;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int bad;
        e = sbq.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_error", 32'(resp_error), 32'(e.err));
        check("resp_cycle", 32'(cyc), 32'(e.due));
        bad = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem_chk[i] !== e.snap[i]) bad++;
        check("mem_words_differing", 32'(bad), 32'd0);
      end
    end
  end

  // Throughput checkers for the zero- and three-cycle-latency instances
  int last0 = -1, nacc0 = 0, last3 = -1, nacc3 = 0;
  always @(negedge clk) begin
    if (rv0) begin
      check("tp_rdata_l0", rd0, 32'hDEADBEEF);
      check("tp_error_l0", 32'(er0), 32'd0);
      check("tp_resp_cycle_l0", 32'(cyc), 32'(last0 + 2));
    end
    if (tp_valid && rdy0) begin
      if (last0 >= 0) check("tp_spacing_l0", 32'(cyc - last0), 32'd2);
      last0 = cyc;
      nacc0++;
    end
    if (rv3) begin
      check("tp_rdata_l3", rd3, 32'hDEADBEEF);
      check("tp_error_l3", 32'(er3), 32'd0);
      check("tp_resp_cycle_l3", 32'(cyc), 32'(last3 + 5));
    end
    if (tp_valid && rdy3) begin
      if (last3 >= 0) check("tp_spacing_l3", 32'(cyc - last3), 32'd5);
      last3 = cyc;
      nacc3++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [2:0] r;
    logic [1:0] sz;
    logic [31:0] a;
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; tp_valid = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) init_vals[i] = $urandom;
    init_vals[3] = 32'hDEADBEEF;
    model = init_vals;
    @(negedge clk);
    do_reset();

    // Word load and ready profile through WAIT and RESP
    send(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0);
    check("ready_in_wait", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_in_resp", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_back_idle", 32'(req_ready), 32'd1);
    wait_idle();

    // Byte store and extended loads
    send(1'b1, 2'b00, 1'b0, 32'h0D, 32'h1234_56A5);
    wait_idle();
    check("byte_store_word3", mem_chk[3], 32'hDEADA5EF);
    send(1'b0, 2'b00, 1'b0, 32'h0D, 32'd0);
    send(1'b0, 2'b00, 1'b1, 32'h0D, 32'd0);

    // Halfword store into the upper half of word 4
    send(1'b1, 2'b01, 1'b0, 32'h12, 32'hFFFF_8001);
    send(1'b0, 2'b01, 1'b0, 32'h12, 32'd0);
    wait_idle();
    check("half_store_low_kept", 32'(mem_chk[4][15:0]), 32'(init_vals[4][15:0]));
    check("half_store_high", 32'(mem_chk[4][31:16]), 32'h8001);

    // Misaligned, illegal size and out-of-range accesses
    send(1'b0, 2'b10, 1'b0, 32'h02, 32'd0);
    send(1'b0, 2'b01, 1'b0, 32'h03, 32'd0);
    send(1'b0, 2'b11, 1'b0, 32'h00, 32'd0);
    send(1'b0, 2'b10, 1'b0, 32'h80, 32'd0);
    send(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFE_F00D);
    send(1'b1, 2'b10, 1'b0, 32'h7C, 32'h0BAD_CAFE);
    wait_idle();

    // Reset while a store waits: nothing commits, no response
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h1234_5678;
    while (!req_ready) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    do_reset();
    check("abort_word4_unchanged", mem_chk[4], init_vals[4]);
    repeat (4) @(negedge clk);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      r  = 3'($urandom_range(0, 7));
      sz = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 + 7));
      send(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();

`ifdef DMEM_ERR_COUNT_EN
    do_reset();
    check("err_count_after_reset", 32'(err_count), 32'd0);
    send(1'b0, 2'b11, 1'b0, 32'h0, 32'd0);
    send(1'b1, 2'b10, 1'b0, 32'h1, 32'd0);
    send(1'b0, 2'b10, 1'b0, 32'h400, 32'd0);
    wait_idle();
    @(negedge clk);
    check("err_count_three", 32'(err_count), 32'd3);
    do_reset();
    check("err_count_cleared", 32'(err_count), 32'd0);
`endif

    // Back-to-back throughput with req_valid held high
    @(posedge clk); #1 tp_valid = 1'b1;
    repeat (40) @(posedge clk);
    #1 tp_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("tp_accepts_l0", 32'(nacc0 >= 18), 32'd1);
    check("tp_accepts_l3", 32'(nacc3 >= 7), 32'd1);
    check("tp_mem_l0", mem_chk0[3], 32'hDEADBEEF);
    check("tp_mem_l3", mem_chk3[3], 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
